// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: requester handshake plus multiplier operand/result bus.
// slave  : arbiter view (takes requests, drives the multiplier)
// master : environment view (requesters and the multiplier)
interface booth_mul_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_m;
  logic [NREQ*WIDTH-1:0] req_q;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_data;
  logic                  busy;
  logic [WIDTH-1:0]      mul_m;
  logic [WIDTH-1:0]      mul_q;
  logic                  mul_start;
  logic [2*WIDTH-1:0]    mul_result;
  logic                  mul_done;

  modport slave (
    input  req_valid, req_m, req_q, mul_result, mul_done,
    output req_ready, rsp_valid, rsp_data, busy, mul_m, mul_q, mul_start
  );

  modport master (
    output req_valid, req_m, req_q, mul_result, mul_done,
    input  req_ready, rsp_valid, rsp_data, busy, mul_m, mul_q, mul_start
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one unsigned Booth multiplier among NREQ requesters.
// Optional feature macro BOOTH_ARB_RR_EN: round-robin arbitration with a rotating
// pointer. Without it, fixed priority (lowest index wins) and no pointer register.
module booth_mul_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0]  mul_m_q, mul_m_d;
  logic [WIDTH-1:0]  mul_q_q, mul_q_d;
  logic [PW-1:0]     rsp_data_q, rsp_data_d;
  logic              mul_start_q, mul_start_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic [IW-1:0]     gsel_c;
  logic              any_req_c;
  logic [NREQ-1:0]   req_ready_c;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign any_req_c = |bus.req_valid;

`ifdef BOOTH_ARB_RR_EN
  localparam int unsigned SW = IW + 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] rr_idx_c;
  logic          rr_found_c;

  // Round-robin pick: first pending requester at or after the pointer, wrapping.
  always_comb begin
    gsel_c     = '0;
    rr_found_c = 1'b0;
    rr_idx_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rr_idx_c = {1'b0, ptr_q} + SW'(i);
      if (rr_idx_c >= SW'(NREQ)) begin
        rr_idx_c = rr_idx_c - SW'(NREQ);
      end
      if (!rr_found_c && bus.req_valid[rr_idx_c[IW-1:0]]) begin
        gsel_c     = rr_idx_c[IW-1:0];
        rr_found_c = 1'b1;
      end
    end
  end
`else
  // Fixed priority pick: lowest pending index wins.
  always_comb begin
    gsel_c = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gsel_c = IW'(i);
      end
    end
  end
`endif

  // Accept strobe is combinational and only offered while idle and out of reset.
  assign req_ready_c = (state_q == S_IDLE && any_req_c && !rst) ? onehot(gsel_c) : '0;

  // Next-state, operand capture, result capture and registered strobes.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    rsp_data_d  = rsp_data_q;
    mul_start_d = 1'b0;
    rsp_valid_d = '0;
    busy_d      = 1'b0;
`ifdef BOOTH_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          grant_d = gsel_c;
          mul_m_d = bus.req_m[32'(gsel_c) * WIDTH +: WIDTH];
          mul_q_d = bus.req_q[32'(gsel_c) * WIDTH +: WIDTH];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_done) begin
          rsp_data_d = bus.mul_result;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
`ifdef BOOTH_ARB_RR_EN
        ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mul_start_d = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP) ? onehot(grant_d) : '0;
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      rsp_data_q  <= '0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
`ifdef BOOTH_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      rsp_data_q  <= rsp_data_d;
      mul_start_q <= mul_start_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef BOOTH_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.mul_m     = mul_m_q;
  assign bus.mul_q     = mul_q_q;
  assign bus.mul_start = mul_start_q;

endmodule
